snn_layer_seq: RTL
==================

// Module: snn_layer_seq
// PURPOSE
//  Sequencer for one fully-connected SNN layer: N_OUT neurons, each with N_IN inputs.
//  Drives the shared MAC, the input/weight memory addresses and the activation-RAM write.
//  Two instances (784->32 hidden, 32->10 output) run back-to-back under the top-level FSM.
//  Control only: no datapath arithmetic. Operand muxing and LUT rectification are external.
// PARAMETERS
//  N_IN     784  inputs per neuron (>=2)
//  N_OUT    32   neurons in the layer (>=1)
//  RD_LAT   1    cycles from in_addr/wt_addr to operand valid at MAC inputs (0..3)
//  MAC_LAT  1    cycles from mac_en to accumulator updated (>=1)
//  LUT_LAT  1    cycles from accumulator to activation LUT output valid (>=0)
// PORTS
//  clk       in   1                     clock, rising edge
//  rst_n     in   1                     reset, asynchronous, active-low
//  start     in   1                     begin a layer pass; sampled only in IDLE
//  abort     in   1                     synchronous cancel of a pass in progress
//  busy      out  1                     high in ISSUE/DRAIN/WRITE
//  done      out  1                     one-cycle pulse when the last neuron is written
//  in_addr   out  $clog2(N_IN)          input-unit read address
//  wt_addr   out  $clog2(N_IN*N_OUT)    weight ROM read address (= neuron*N_IN + i)
//  out_addr  out  $clog2(N_OUT)         neuron index / activation RAM write address
//  mac_clr   out  1                     synchronous accumulator clear
//  mac_en    out  1                     accumulate the operands present this cycle
//  wr_en     out  1                     write the LUT output to activation RAM at out_addr
// BEHAVIOUR
//  Reset: state IDLE; every output 0 and every address 0; mac_en pipeline flushed.
//  All outputs are registered or decoded from the registered state.
//  D = RD_LAT+MAC_LAT+LUT_LAT.
//  IDLE: busy=0 and addresses held at 0.
//    start=1: mac_clr=1 this cycle, go to ISSUE.
//  ISSUE: runs N_IN cycles. in_addr steps 0..N_IN-1 and wt_addr increments by 1 each cycle.
//    A one-bit issue flag enters an RD_LAT-deep shift register; its output is mac_en.
//    With RD_LAT=0, mac_en equals the issue flag.
//    When in_addr==N_IN-1: go to DRAIN, in_addr wraps to 0, wt_addr keeps its next value.
//  DRAIN: runs exactly D cycles. It waits for the last product to accumulate and for the
//    LUT to settle. mac_en pulses still in flight continue to be output.
//  WRITE: runs 1 cycle, wr_en=1 at the current out_addr.
//    If out_addr==N_OUT-1: go to DONE.
//    Otherwise: out_addr+1, mac_clr=1, go to ISSUE.
//    The clear takes effect after the write edge, so the written data is unaffected.
//  DONE: runs 1 cycle, done=1 and busy=0. Go to IDLE, and all addresses clear to 0.
//  Per-neuron cost is N_IN+D+1 cycles.
//    done is asserted in cycle N_OUT*(N_IN+D+1)+1 after the edge that samples start.
//  mac_en is asserted exactly N_IN*N_OUT times per pass, always in N_IN-long bursts.
//    mac_en is never asserted in the same cycle as mac_clr.
//  start while busy or in DONE: ignored. No restart and no queuing.
//    start held high continuously: a new pass begins on the first IDLE cycle after DONE.
//  abort (ISSUE/DRAIN/WRITE): next state IDLE; addresses clear and the mac_en pipeline flushes.
//    No done pulse. wr_en=0 in the abort cycle. abort has priority over WRITE and start.
//  abort in IDLE or DONE: no effect; done still pulses if the state is DONE.
//  rst_n low mid-pass: all outputs go to 0 immediately, with no partial write or done.
//  wt_addr never exceeds N_IN*N_OUT-1, and out_addr never exceeds N_OUT-1.
// TESTING (params N_IN=4, N_OUT=3, all LAT=1, so D=3, unless noted)
//  1. Reset: rst_n=0 -> busy, done, mac_clr, mac_en and wr_en are 0, and all addresses are 0.
//     Check this also holds while clk toggles.
//  2. Single pass: start pulse -> mac_clr high in the start cycle.
//     wt_addr 0..11 in 3 bursts of 4; mac_en 12 pulses, each 1 cycle after its address.
//     wr_en at out_addr 0,1,2 in cycles 8,16,24; done only in cycle 25; busy in cycles 1..24.
//  3. start held high for 60 cycles -> passes begin at cycles 1 and 27.
//     A start pulse in cycle 10 of a pass causes no restart and no extra wr_en.
//  4. abort in cycle 10 (neuron 1, in_addr=1) -> IDLE in cycle 11 with busy=0 and addresses 0.
//     No further mac_en/wr_en and no done pulse. A fresh start then runs a clean 25-cycle pass.
//  5. rst_n asserted in a DRAIN cycle of neuron 2 -> immediate all-zero outputs; no wr_en.
//     After release, start gives normal behaviour.
//  6. Defaults (784/32/1/1/1) -> done in cycle 25217; final wt_addr 25087.
//     25088 mac_en pulses; 32 wr_en pulses.

Source files
------------

// File: rtl/snn_layer_seq.sv
// Control sequencer for one fully-connected SNN layer: walks input/weight addresses per
// neuron, gates the shared MAC through the read-latency pipe and writes each activation once.
module snn_layer_seq #(
    parameter int N_IN    = 784,
    parameter int N_OUT   = 32,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 1,
    parameter int LUT_LAT = 1,
    localparam int IW = $clog2(N_IN),
    localparam int WW = $clog2(N_IN * N_OUT),
    localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] in_addr,
    output logic [WW-1:0] wt_addr,
    output logic [OW-1:0] out_addr,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          wr_en
);

    localparam int D  = RD_LAT + MAC_LAT + LUT_LAT;
    localparam int DW = $clog2(D + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] drain_cnt;
    logic          last_in;
    logic          last_out;
    logic          issue;
    logic          stop;

    assign last_in  = (in_addr == IW'(N_IN - 1));
    assign last_out = (out_addr == OW'(N_OUT - 1));
    assign issue    = (state == S_ISSUE);
    assign busy     = (state == S_ISSUE) || (state == S_DRAIN) || (state == S_WRITE);
    assign done     = (state == S_DONE);
    assign stop     = abort & busy;

    // The clear and the write are decoded in the same cycle the decision is taken, so an
    // abort suppresses the write and an IDLE start clears before the first product lands.
    assign wr_en   = (state == S_WRITE) & ~abort;
    assign mac_clr = ((state == S_IDLE) & start) | ((state == S_WRITE) & ~abort & ~last_out);

    generate
        if (RD_LAT == 0) begin : g_no_pipe
            assign mac_en = issue;
        end else begin : g_pipe
            logic [RD_LAT-1:0] pipe;

            // NOTE: clocked state uses non-blocking assignments only, so every stage
            // shifts on the value it held before the edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe <= '0;
                end else if (stop) begin
                    pipe <= '0;
                end else begin
                    pipe <= (pipe << 1) | RD_LAT'(issue);
                end
            end

            assign mac_en = pipe[RD_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_addr   <= '0;
            wt_addr   <= '0;
            out_addr  <= '0;
            drain_cnt <= '0;
        end else if (stop) begin
            state     <= S_IDLE;
            in_addr   <= '0;
            wt_addr   <= '0;
            out_addr  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    // Hold the weight address on the very last operand of the pass.
                    if (!(last_in && last_out)) wt_addr <= wt_addr + 1'b1;
                    if (last_in) begin
                        in_addr   <= '0;
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                    end else begin
                        in_addr <= in_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DW'(D - 1)) state <= S_WRITE;
                    else drain_cnt <= drain_cnt + 1'b1;
                end
                S_WRITE: begin
                    if (last_out) begin
                        state <= S_DONE;
                    end else begin
                        out_addr <= out_addr + 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    in_addr  <= '0;
                    wt_addr  <= '0;
                    out_addr <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
